async_oneway_transmitter: RTL and testbench

Transmit end of the one-way asynchronous link. Serialises a MESSAGE_SIZE-bit message into 6-bit chunks on `dout`, qualified by `packet_pulse` and framed by `transmit_ctrl`, for a receiver clocked from an unrelated clock that debounces every line and edge-detects each line.
Every phase is held for a parameterised number of `clk_transmit` cycles so the receiver's debouncer sees stable levels. Sits on the sending board/domain; the message source drives `start` + `message`.

---
 rtl/async_oneway_transmitter_pkg.sv | 26 ++
 rtl/async_oneway_transmitter_phase_timer.sv | 33 +++
 rtl/async_oneway_transmitter.sv | 150 +++++++++++++++
 tb/tb_async_oneway_transmitter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/async_oneway_transmitter_pkg.sv
// Shared constants and types for the one-way asynchronous link (transmit and receive ends).
package async_oneway_transmitter_pkg;

  localparam int MESSAGE_SIZE = 20;
  localparam int CHUNK_WIDTH  = 6;
  localparam int CHUNKS       = MESSAGE_SIZE / CHUNK_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TAIL  = 3'd4,
    ST_COOL  = 3'd5
  } tx_state_e;

  // The extra chunk keeps the receiver aligned even when the size is a multiple of 6.
  function automatic int chunks_for(input int msg_bits);
    return msg_bits / CHUNK_WIDTH + 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/async_oneway_transmitter_phase_timer.sv
// Down-counter timing each transmitter phase; expired while the count sits at zero.
module async_oneway_transmitter_phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/async_oneway_transmitter.sv
// Transmit end of the one-way asynchronous link: frames a message into slow,
// debouncer-friendly 6-bit chunks strobed by packet_pulse.
module async_oneway_transmitter
  import async_oneway_transmitter_pkg::*;
#(
  parameter int MSG_W        = MESSAGE_SIZE,
  parameter int SETUP_CYCLES = 16,
  parameter int HOLD_CYCLES  = 16,
  parameter int GAP_CYCLES   = 16,
  parameter int TAIL_CYCLES  = 16,
  parameter int IDLE_CYCLES  = 16
) (
  input  logic             clk_transmit,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MSG_W-1:0] message,
  output logic             busy,
  output logic             done,
  output logic             transmit_ctrl,
  output logic             packet_pulse,
  output logic [5:0]       dout
);

  localparam int NCH     = chunks_for(MSG_W);
  localparam int SR_W    = NCH * CHUNK_WIDTH;
  localparam int MAX_CYC = max2(max2(max2(SETUP_CYCLES, HOLD_CYCLES),
                                     max2(GAP_CYCLES, TAIL_CYCLES)), IDLE_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = $clog2(NCH) + 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TAIL_LD  = CNT_W'(TAIL_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  if (SETUP_CYCLES < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1 ||
      TAIL_CYCLES < 1 || IDLE_CYCLES < 1) begin : g_param_check
    $error("async_oneway_transmitter: every phase length must be at least 1 cycle");
  end

  tx_state_e        state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tmr_load, tmr_expired;
  logic [CNT_W-1:0] tmr_val;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ctrl_q, ctrl_d;
  logic             pulse_q, pulse_d;
  logic [5:0]       dout_q, dout_d;

  async_oneway_transmitter_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (clk_transmit),
    .rst_ni     (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          sr_d    = SR_W'(message);
          idx_d   = '0;
        end
      end
      ST_SETUP: if (tmr_expired) state_d = ST_HIGH;
      ST_HIGH:  if (tmr_expired) state_d = ST_LOW;
      ST_LOW: begin
        if (tmr_expired) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_TAIL;
          end else begin
            state_d = ST_HIGH;
            sr_d    = sr_q >> CHUNK_WIDTH;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      ST_TAIL:  if (tmr_expired) state_d = ST_COOL;
      ST_COOL:  if (tmr_expired) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Each state entry reloads the timer so the state lasts exactly its phase length.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    unique case (state_d)
      ST_SETUP: tmr_val = SETUP_LD;
      ST_HIGH:  tmr_val = HOLD_LD;
      ST_LOW:   tmr_val = GAP_LD;
      ST_TAIL:  tmr_val = TAIL_LD;
      ST_COOL:  tmr_val = IDLE_LD;
      default:  tmr_val = '0;
    endcase
  end

  // Outputs decode the next state, so data and pulse rise on the same edge.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    ctrl_d  = (state_d == ST_SETUP) || (state_d == ST_HIGH) ||
              (state_d == ST_LOW)   || (state_d == ST_TAIL);
    pulse_d = (state_d == ST_HIGH);
    dout_d  = pulse_d ? sr_d[CHUNK_WIDTH-1:0] : 6'd0;
    done_d  = (state_q == ST_TAIL) && (state_d == ST_COOL);
  end

  always_ff @(posedge clk_transmit) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ctrl_q  <= 1'b0;
      pulse_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ctrl_q  <= ctrl_d;
      pulse_q <= pulse_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk_transmit) begin
    sr_q <= sr_d;
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign transmit_ctrl = ctrl_q;
  assign packet_pulse  = pulse_q;
  assign dout          = dout_q;

endmodule

// File: tb/tb_async_oneway_transmitter.sv
// Directed bench for async_oneway_transmitter: a 20-bit and a 24-bit instance on one clock.
module tb_async_oneway_transmitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start20, start24;
  logic [19:0] msg20;
  logic [23:0] msg24;
  logic        busy20, done20, tc20, p20;
  logic [5:0]  dout20;
  logic        busy24, done24, tc24, p24;
  logic [5:0]  dout24;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  async_oneway_transmitter #(.MSG_W(20)) dut20 (
    .clk_transmit (clk),
    .rst_n        (rst_n),
    .start        (start20),
    .message      (msg20),
    .busy         (busy20),
    .done         (done20),
    .transmit_ctrl(tc20),
    .packet_pulse (p20),
    .dout         (dout20)
  );

  async_oneway_transmitter #(.MSG_W(24)) dut24 (
    .clk_transmit (clk),
    .rst_n        (rst_n),
    .start        (start24),
    .message      (msg24),
    .busy         (busy24),
    .done         (done24),
    .transmit_ctrl(tc24),
    .packet_pulse (p24),
    .dout         (dout24)
  );

  typedef struct {
    int         k;
    logic       busy;
    logic       tc;
    logic       pulse;
    logic       done;
    logic [5:0] dout;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {busy, transmit_ctrl, packet_pulse, done, dout}
  function automatic logic [9:0] obs(input int sel);
    if (sel == 0) return {busy20, tc20, p20, done20, dout20};
    return {busy24, tc24, p24, done24, dout24};
  endfunction

  task automatic drive_start(input int sel, input logic s, input logic [23:0] m);
    if (sel == 0) begin
      start20 = s;
      msg20   = m[19:0];
    end else begin
      start24 = s;
      msg24   = m;
    end
  endtask

  task automatic wait_idle(input int sel, input string tag);
    int n = 0;
    while (obs(sel) != 10'd0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " return to idle"}, obs(sel), 10'd0);
  endtask

  // One full frame: chunk values, pulse widths, gaps, done, busy length.
  task automatic run_frame(input int sel, input logic [23:0] msg, input int exp_chunks,
                           input bit poke, input string tag);
    int k = 0, blen = 0, npulse = 0, hi_run = 0, ndone = 0;
    int bad_gap = 0, bad_pw = 0, bad_done = 0, extra = 0;
    logic prev_p = 1'b0, prev_tc = 1'b1;
    logic [9:0] o;
    logic [5:0] chunk_exp;
    drive_start(sel, 1'b1, msg);
    @(negedge clk);
    drive_start(sel, 1'b0, ~msg);
    while (k < 600) begin
      o = obs(sel);
      if (!o[9]) break;
      blen++;
      if (o[7] && !prev_p) begin
        chunk_exp = 6'((msg >> (6 * npulse)) & 24'h3F);
        chk($sformatf("%s chunk%0d", tag, npulse), o[5:0], chunk_exp);
        npulse++;
      end
      if (!o[7] && o[5:0] != 6'd0) bad_gap++;
      if (o[7]) hi_run++;
      else if (prev_p) begin
        if (hi_run != 16) bad_pw++;
        hi_run = 0;
      end
      if (o[6]) begin
        ndone++;
        if (!(prev_tc && !o[8])) bad_done++;
      end
      prev_p  = o[7];
      prev_tc = o[8];
      if (poke) drive_start(sel, (k == 5 || k == 20 || k == 165), ~msg);
      @(negedge clk);
      k++;
    end
    drive_start(sel, 1'b0, ~msg);
    chk({tag, " busy length"}, blen, 16 + exp_chunks * 32 + 32);
    chk({tag, " pulse count"}, npulse, exp_chunks);
    chk({tag, " done count"}, ndone, 1);
    chk({tag, " dout low outside pulse"}, bad_gap, 0);
    chk({tag, " pulse width"}, bad_pw, 0);
    chk({tag, " done with ctrl fall"}, bad_done, 0);
    if (poke) begin
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (obs(sel)[9]) extra++;
      end
      chk({tag, " no queued frame"}, extra, 0);
    end
  endtask

  initial begin
    int k;
    int lo;
    logic [23:0] r;

    tbl[0]  = '{0,   1'b1, 1'b1, 1'b0, 1'b0, 6'h00};
    tbl[1]  = '{15,  1'b1, 1'b1, 1'b0, 1'b0, 6'h00};
    tbl[2]  = '{16,  1'b1, 1'b1, 1'b1, 1'b0, 6'h1E};
    tbl[3]  = '{31,  1'b1, 1'b1, 1'b1, 1'b0, 6'h1E};
    tbl[4]  = '{32,  1'b1, 1'b1, 1'b0, 1'b0, 6'h00};
    tbl[5]  = '{47,  1'b1, 1'b1, 1'b0, 1'b0, 6'h00};
    tbl[6]  = '{48,  1'b1, 1'b1, 1'b1, 1'b0, 6'h33};
    tbl[7]  = '{80,  1'b1, 1'b1, 1'b1, 1'b0, 6'h2B};
    tbl[8]  = '{112, 1'b1, 1'b1, 1'b1, 1'b0, 6'h02};
    tbl[9]  = '{127, 1'b1, 1'b1, 1'b1, 1'b0, 6'h02};
    tbl[10] = '{128, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00};
    tbl[11] = '{143, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00};
    tbl[12] = '{144, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00};
    tbl[13] = '{159, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00};
    tbl[14] = '{160, 1'b1, 1'b0, 1'b0, 1'b1, 6'h00};
    tbl[15] = '{161, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00};
    tbl[16] = '{175, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00};
    tbl[17] = '{176, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00};

    rst_n   = 1'b0;
    start20 = 1'b1;
    start24 = 1'b0;
    msg20   = 20'hABCDE;
    msg24   = 24'h0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset outputs cycle %0d", i), obs(0), 10'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("first start after reset", obs(0), {1'b1, 1'b1, 1'b0, 1'b0, 6'h00});
    start20 = 1'b0;
    wait_idle(0, "after reset frame");

    // Table: 20'hABCDE, sampled k cycles after the accepting edge.
    drive_start(0, 1'b1, 24'hABCDE);
    @(negedge clk);
    drive_start(0, 1'b0, 24'h55555);
    k = 0;
    foreach (tbl[i]) begin
      while (k < tbl[i].k) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("vec k=%0d", tbl[i].k), obs(0),
          {tbl[i].busy, tbl[i].tc, tbl[i].pulse, tbl[i].done, tbl[i].dout});
    end

    @(negedge clk);
    run_frame(0, 24'hABCDE, 4, 1'b0, "abcde");
    run_frame(0, 24'h00000, 4, 1'b0, "zeros");
    for (int i = 0; i < 3; i++) begin
      r = 24'($urandom) & 24'h0FFFFF;
      run_frame(0, r, 4, 1'b0, $sformatf("rand20_%0d", i));
    end
    run_frame(1, 24'hFFFFFF, 5, 1'b0, "ffffff24");
    run_frame(1, 24'($urandom), 5, 1'b0, "rand24");

    run_frame(0, 24'h3C5A6, 4, 1'b1, "start while busy");

    // Reset during the second HIGH phase abandons the frame.
    drive_start(0, 1'b1, 24'h12345);
    @(negedge clk);
    drive_start(0, 1'b0, 24'h0);
    repeat (52) @(negedge clk);
    chk("mid-frame second chunk", obs(0), {1'b1, 1'b1, 1'b1, 1'b0, 6'h0D});
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid-frame reset outputs", obs(0), 10'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no done after reset", obs(0), 10'd0);
    run_frame(0, 24'h0F0F0, 4, 1'b0, "after mid reset");

    // Held start: COOL lasts 16 cycles and one IDLE cycle precedes the next accept.
    start20 = 1'b1;
    msg20   = 20'h13579;
    k = 0;
    while (!busy20 && k < 10) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (busy20 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("held start first frame ends", busy20, 1'b0);
    lo = 0;
    k  = 0;
    while (!tc20 && k < 100) begin
      @(negedge clk);
      k++;
      lo++;
    end
    chk("held start ctrl low run", lo + 16, 17);
    chk("held start second frame", tc20, 1'b1);
    start20 = 1'b0;
    wait_idle(0, "held start");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
